// File: rtl/sisc_pkg.sv
// Shared types and encodings for the SISC control unit: FSM states,
// opcodes, addressing-mode constant, ALU operation and write-back codes.
package sisc_pkg;

   typedef enum logic [2:0] {
      ST_RESET   = 3'd0,
      ST_FETCH   = 3'd1,
      ST_DECODE  = 3'd2,
      ST_EXECUTE = 3'd3,
      ST_MEM     = 3'd4,
      ST_WB      = 3'd5,
      ST_HALT    = 3'd6
   } state_t;

   localparam logic [3:0] OP_NOOP = 4'd0;
   localparam logic [3:0] OP_LOD  = 4'd1;
   localparam logic [3:0] OP_STR  = 4'd2;
   localparam logic [3:0] OP_SWP  = 4'd3;
   localparam logic [3:0] OP_BRA  = 4'd4;
   localparam logic [3:0] OP_BRR  = 4'd5;
   localparam logic [3:0] OP_BNE  = 4'd6;
   localparam logic [3:0] OP_BNR  = 4'd7;
   localparam logic [3:0] OP_ALU  = 4'd8;
   localparam logic [3:0] OP_HLT  = 4'd15;

   localparam logic [3:0] AM_IMM  = 4'd8;

   localparam logic [1:0] ALU_REG  = 2'd0;
   localparam logic [1:0] ALU_IMM  = 2'd1;
   localparam logic [1:0] ALU_ADDR = 2'd2;
   localparam logic [1:0] ALU_SWP  = 2'd3;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_SWP = 2'd2;

endpackage

// File: rtl/sisc_br_eval.sv
// Branch-taken evaluation: BRA/BRR taken on any masked status bit set,
// BNE/BNR taken when no masked status bit is set.
module sisc_br_eval
   import sisc_pkg::*;
#(
   parameter int OPC_W  = 4,
   parameter int MM_W   = 4,
   parameter int STAT_W = 4
) (
   input  logic [OPC_W-1:0]  opcode,
   input  logic [MM_W-1:0]   mm,
   input  logic [STAT_W-1:0] stat,
   output logic              taken
);

   logic any_set;
   logic br_pos;
   logic br_neg;

   assign any_set = |(mm & stat);
   assign br_pos  = (opcode == OPC_W'(OP_BRA)) || (opcode == OPC_W'(OP_BRR));
   assign br_neg  = (opcode == OPC_W'(OP_BNE)) || (opcode == OPC_W'(OP_BNR));
   assign taken   = (br_pos && any_set) || (br_neg && !any_set);

endmodule

// File: rtl/sisc_ctrl_p.sv
// Multi-cycle SISC control FSM (FETCH/DECODE/EXECUTE/MEM/WB/HALT).
// Define SISC_CTRL_MEMWAIT_EN to stall MEM on mem_rdy for LOD/STR.
module sisc_ctrl_p
   import sisc_pkg::*;
#(
   parameter int OPC_W    = 4,
   parameter int MM_W     = 4,
   parameter int STAT_W   = 4,
   parameter int ALU_OP_W = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPC_W-1:0]    opcode,
   input  logic [MM_W-1:0]     mm,
   input  logic [STAT_W-1:0]   stat,
   input  logic                mem_rdy,
   output logic                ir_load,
   output logic                pc_write,
   output logic                pc_sel,
   output logic                br_sel,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                stat_en,
   output logic                dm_we,
   output logic                rf_we,
   output logic [1:0]          wb_sel,
   output logic                illegal,
   output logic                halted
);

   state_t state;
   state_t state_nxt;

   logic is_noop, is_lod, is_str, is_swp, is_bra, is_brr, is_bne, is_bnr, is_alu, is_hlt;
   logic is_defined;
   logic taken;
   logic mem_hold;
   logic [ALU_OP_W-1:0] alu_code;

   assign is_noop = (opcode == OPC_W'(OP_NOOP));
   assign is_lod  = (opcode == OPC_W'(OP_LOD));
   assign is_str  = (opcode == OPC_W'(OP_STR));
   assign is_swp  = (opcode == OPC_W'(OP_SWP));
   assign is_bra  = (opcode == OPC_W'(OP_BRA));
   assign is_brr  = (opcode == OPC_W'(OP_BRR));
   assign is_bne  = (opcode == OPC_W'(OP_BNE));
   assign is_bnr  = (opcode == OPC_W'(OP_BNR));
   assign is_alu  = (opcode == OPC_W'(OP_ALU));
   assign is_hlt  = (opcode == OPC_W'(OP_HLT));

   assign is_defined = is_noop | is_lod | is_str | is_swp | is_bra | is_brr |
                       is_bne | is_bnr | is_alu | is_hlt;

   sisc_br_eval #(
      .OPC_W  (OPC_W),
      .MM_W   (MM_W),
      .STAT_W (STAT_W)
   ) u_br_eval (
      .opcode (opcode),
      .mm     (mm),
      .stat   (stat),
      .taken  (taken)
   );

`ifdef SISC_CTRL_MEMWAIT_EN
   assign mem_hold = (is_lod | is_str) & ~mem_rdy;
`else
   logic unused_mem_rdy;
   assign unused_mem_rdy = mem_rdy;
   assign mem_hold       = 1'b0;
`endif

   always_comb begin
      alu_code = '0;
      if (is_alu)
         alu_code = (mm == MM_W'(AM_IMM)) ? ALU_OP_W'(ALU_IMM) : ALU_OP_W'(ALU_REG);
      else if (is_lod || is_str)
         alu_code = ALU_OP_W'(ALU_ADDR);
      else if (is_swp)
         alu_code = ALU_OP_W'(ALU_SWP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_RESET;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ir_load   = 1'b0;
      pc_write  = 1'b0;
      pc_sel    = 1'b0;
      br_sel    = 1'b0;
      alu_op    = '0;
      stat_en   = 1'b0;
      dm_we     = 1'b0;
      rf_we     = 1'b0;
      wb_sel    = '0;
      illegal   = 1'b0;
      halted    = 1'b0;
      case (state)
         ST_RESET: state_nxt = ST_FETCH;
         ST_FETCH: begin
            ir_load   = 1'b1;
            pc_write  = 1'b1;
            state_nxt = ST_DECODE;
         end
         ST_DECODE: begin
            illegal   = ~is_defined;
            state_nxt = is_hlt ? ST_HALT : ST_EXECUTE;
         end
         ST_EXECUTE: begin
            alu_op    = alu_code;
            stat_en   = is_alu;
            // stat is only looked at here, so later changes cannot redirect the PC
            if (taken) begin
               pc_write = 1'b1;
               pc_sel   = 1'b1;
               br_sel   = is_brr | is_bnr;
            end
            state_nxt = ST_MEM;
         end
         ST_MEM: begin
            alu_op    = alu_code;
            dm_we     = is_str;
            state_nxt = mem_hold ? ST_MEM : ST_WB;
         end
         ST_WB: begin
            rf_we = is_alu | is_lod | is_swp;
            if (is_lod)
               wb_sel = WB_MEM;
            else if (is_swp)
               wb_sel = WB_SWP;
            else
               wb_sel = WB_ALU;
            state_nxt = ST_FETCH;
         end
         ST_HALT: halted = 1'b1;
         default: state_nxt = ST_RESET;
      endcase
   end

endmodule

// File: tb/tb_sisc_ctrl_p.sv
// Scoreboard bench for sisc_ctrl_p: each queue entry holds one cycle of
// stimulus plus the expected output vector for that cycle.
module tb_sisc_ctrl_p;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] opcode;
   logic [3:0] mm;
   logic [3:0] stat;
   logic       mem_rdy;
   logic       ir_load, pc_write, pc_sel, br_sel, stat_en, dm_we, rf_we, illegal, halted;
   logic [1:0] alu_op;
   logic [1:0] wb_sel;

   int tests  = 0;
   int failed = 0;

   typedef struct {
      logic        r;
      logic [3:0]  op;
      logic [3:0]  m;
      logic [3:0]  s;
      logic        rdy;
      logic [12:0] exp;
      string       name;
   } ent_t;

   ent_t sb[$];

   localparam logic [12:0] Z = 13'd0;

   sisc_ctrl_p #(
      .OPC_W    (4),
      .MM_W     (4),
      .STAT_W   (4),
      .ALU_OP_W (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .opcode   (opcode),
      .mm       (mm),
      .stat     (stat),
      .mem_rdy  (mem_rdy),
      .ir_load  (ir_load),
      .pc_write (pc_write),
      .pc_sel   (pc_sel),
      .br_sel   (br_sel),
      .alu_op   (alu_op),
      .stat_en  (stat_en),
      .dm_we    (dm_we),
      .rf_we    (rf_we),
      .wb_sel   (wb_sel),
      .illegal  (illegal),
      .halted   (halted)
   );

   always #5 clk = ~clk;

   // {ir_load,pc_write,pc_sel,br_sel,alu_op,stat_en,dm_we,rf_we,wb_sel,illegal,halted}
   function automatic logic [12:0] mk(input bit ir, input bit pcw, input bit pcs, input bit brs,
                                      input logic [1:0] alu, input bit sten, input bit dm,
                                      input bit rf, input logic [1:0] wb, input bit ill,
                                      input bit hlt);
      return {ir, pcw, pcs, brs, alu, sten, dm, rf, wb, ill, hlt};
   endfunction

   function automatic logic [12:0] vf();
      return mk(1, 1, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0);
   endfunction

   task automatic push(input logic r, input logic [3:0] op, input logic [3:0] m,
                       input logic [3:0] s, input logic rdy, input logic [12:0] e,
                       input string n);
      ent_t x;
      x.r = r; x.op = op; x.m = m; x.s = s; x.rdy = rdy; x.exp = e; x.name = n;
      sb.push_back(x);
   endtask

   task automatic instr(input string n, input logic [3:0] op, input logic [3:0] m,
                        input logic [3:0] s, input logic rdy, input logic [12:0] dexp,
                        input logic [12:0] eexp, input logic [12:0] mexp,
                        input logic [12:0] wexp);
      push(0, op, m, s, rdy, vf(), {n, "_fetch"});
      push(0, op, m, s, rdy, dexp, {n, "_decode"});
      push(0, op, m, s, rdy, eexp, {n, "_exec"});
      push(0, op, m, s, rdy, mexp, {n, "_mem"});
      push(0, op, m, s, rdy, wexp, {n, "_wb"});
   endtask

   task automatic drain();
      ent_t        e;
      logic [12:0] act;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(negedge clk);
         rst = e.r; opcode = e.op; mm = e.m; stat = e.s; mem_rdy = e.rdy;
         #1;
         act = {ir_load, pc_write, pc_sel, br_sel, alu_op, stat_en, dm_we, rf_we,
                wb_sel, illegal, halted};
         tests++;
         if (act !== e.exp) begin
            failed++;
            $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
         end
      end
   endtask

   task automatic test_reset();
      push(1, 4'd8, 4'd0, 4'd0, 1, Z, "reset_hold0");
      push(1, 4'd8, 4'd0, 4'd0, 1, Z, "reset_hold1");
      drain();
   endtask

   task automatic test_alu();
      push(0, 4'd8, 4'd0, 4'd0, 1, Z, "alu_release");
      instr("alu_reg", 4'd8, 4'd0, 4'd0, 1, Z,
            mk(0, 0, 0, 0, 2'd0, 1, 0, 0, 2'd0, 0, 0), Z,
            mk(0, 0, 0, 0, 2'd0, 0, 0, 1, 2'd0, 0, 0));
      instr("alu_imm", 4'd8, 4'd8, 4'd0, 1, Z,
            mk(0, 0, 0, 0, 2'd1, 1, 0, 0, 2'd0, 0, 0),
            mk(0, 0, 0, 0, 2'd1, 0, 0, 0, 2'd0, 0, 0),
            mk(0, 0, 0, 0, 2'd0, 0, 0, 1, 2'd0, 0, 0));
      drain();
   endtask

   task automatic test_branch();
      instr("bra_taken", 4'd4, 4'b0010, 4'b0010, 1, Z,
            mk(0, 1, 1, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0), Z, Z);
      instr("bra_not", 4'd4, 4'b0010, 4'b0000, 1, Z, Z, Z, Z);
      instr("brr_taken", 4'd5, 4'b0100, 4'b0110, 1, Z,
            mk(0, 1, 1, 1, 2'd0, 0, 0, 0, 2'd0, 0, 0), Z, Z);
      instr("bne_not", 4'd6, 4'b0011, 4'b0001, 1, Z, Z, Z, Z);
      // status only matters in EXECUTE
      push(0, 4'd4, 4'b0010, 4'b0000, 1, vf(), "bra_late_fetch");
      push(0, 4'd4, 4'b0010, 4'b0000, 1, Z, "bra_late_decode");
      push(0, 4'd4, 4'b0010, 4'b0010, 1, mk(0, 1, 1, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0), "bra_late_exec");
      push(0, 4'd4, 4'b0010, 4'b0000, 1, Z, "bra_late_mem");
      push(0, 4'd4, 4'b0010, 4'b0000, 1, Z, "bra_late_wb");
      push(0, 4'd4, 4'b0010, 4'b0010, 1, vf(), "bra_early_fetch");
      push(0, 4'd4, 4'b0010, 4'b0010, 1, Z, "bra_early_decode");
      push(0, 4'd4, 4'b0010, 4'b0000, 1, Z, "bra_early_exec");
      push(0, 4'd4, 4'b0010, 4'b0010, 1, Z, "bra_early_mem");
      push(0, 4'd4, 4'b0010, 4'b0010, 1, Z, "bra_early_wb");
      drain();
   endtask

   task automatic test_bnr();
      instr("bnr_taken", 4'd7, 4'b0001, 4'b0000, 1, Z,
            mk(0, 1, 1, 1, 2'd0, 0, 0, 0, 2'd0, 0, 0), Z, Z);
      instr("bnr_not", 4'd7, 4'b0001, 4'b0001, 1, Z, Z, Z, Z);
      drain();
   endtask

   task automatic test_mem();
      logic [12:0] st_mem;
      st_mem = mk(0, 0, 0, 0, 2'd2, 0, 1, 0, 2'd0, 0, 0);
      push(0, 4'd2, 4'd0, 4'd0, 0, vf(), "str_fetch");
      push(0, 4'd2, 4'd0, 4'd0, 0, Z, "str_decode");
      push(0, 4'd2, 4'd0, 4'd0, 0, mk(0, 0, 0, 0, 2'd2, 0, 0, 0, 2'd0, 0, 0), "str_exec");
`ifdef SISC_CTRL_MEMWAIT_EN
      push(0, 4'd2, 4'd0, 4'd0, 0, st_mem, "str_mem_w0");
      push(0, 4'd2, 4'd0, 4'd0, 0, st_mem, "str_mem_w1");
      push(0, 4'd2, 4'd0, 4'd0, 0, st_mem, "str_mem_w2");
      push(0, 4'd2, 4'd0, 4'd0, 1, st_mem, "str_mem_rdy");
`else
      push(0, 4'd2, 4'd0, 4'd0, 0, st_mem, "str_mem");
`endif
      push(0, 4'd2, 4'd0, 4'd0, 0, Z, "str_wb");
      instr("lod", 4'd1, 4'd0, 4'd0, 1, Z,
            mk(0, 0, 0, 0, 2'd2, 0, 0, 0, 2'd0, 0, 0),
            mk(0, 0, 0, 0, 2'd2, 0, 0, 0, 2'd0, 0, 0),
            mk(0, 0, 0, 0, 2'd0, 0, 0, 1, 2'd1, 0, 0));
      instr("swp", 4'd3, 4'd0, 4'd0, 1, Z,
            mk(0, 0, 0, 0, 2'd3, 0, 0, 0, 2'd0, 0, 0),
            mk(0, 0, 0, 0, 2'd3, 0, 0, 0, 2'd0, 0, 0),
            mk(0, 0, 0, 0, 2'd0, 0, 0, 1, 2'd2, 0, 0));
      instr("noop_nordy", 4'd0, 4'd0, 4'd0, 0, Z, Z, Z, Z);
      drain();
   endtask

   task automatic test_illegal();
      instr("ill12", 4'd12, 4'd0, 4'd0, 1, mk(0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 1, 0), Z, Z, Z);
      instr("ill9", 4'd9, 4'd8, 4'hF, 1, mk(0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 1, 0), Z, Z, Z);
      drain();
   endtask

   task automatic test_reset_mid();
      push(0, 4'd2, 4'd0, 4'd0, 0, vf(), "rmid_fetch");
      push(0, 4'd2, 4'd0, 4'd0, 0, Z, "rmid_decode");
      push(0, 4'd2, 4'd0, 4'd0, 0, mk(0, 0, 0, 0, 2'd2, 0, 0, 0, 2'd0, 0, 0), "rmid_exec");
      push(0, 4'd2, 4'd0, 4'd0, 0, mk(0, 0, 0, 0, 2'd2, 0, 1, 0, 2'd0, 0, 0), "rmid_mem");
      push(1, 4'd2, 4'd0, 4'd0, 0, Z, "rmid_rst_async");
      push(0, 4'd0, 4'd0, 4'd0, 1, Z, "rmid_release");
      push(0, 4'd0, 4'd0, 4'd0, 1, vf(), "rmid_fetch_after");
      push(0, 4'd0, 4'd0, 4'd0, 1, Z, "rmid_decode_after");
      push(0, 4'd0, 4'd0, 4'd0, 1, Z, "rmid_exec_after");
      push(0, 4'd0, 4'd0, 4'd0, 1, Z, "rmid_mem_after");
      push(0, 4'd0, 4'd0, 4'd0, 1, Z, "rmid_wb_after");
      drain();
   endtask

   task automatic test_halt();
      push(0, 4'd15, 4'd0, 4'd0, 1, vf(), "hlt_fetch");
      push(0, 4'd15, 4'd0, 4'd0, 1, Z, "hlt_decode");
      for (int i = 0; i < 20; i++)
         push(0, (i % 2 == 0) ? 4'd15 : 4'd8, 4'd0, 4'd0, 1,
              mk(0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 1), "hlt_hold");
      push(1, 4'd15, 4'd0, 4'd0, 1, Z, "hlt_rst_async");
      push(1, 4'd15, 4'd0, 4'd0, 1, Z, "hlt_rst_hold");
      push(0, 4'd0, 4'd0, 4'd0, 1, Z, "hlt_release");
      push(0, 4'd0, 4'd0, 4'd0, 1, vf(), "hlt_fetch_after");
      drain();
   endtask

   initial begin
      rst = 1'b1; opcode = '0; mm = '0; stat = '0; mem_rdy = 1'b1;
      test_reset();
      test_alu();
      test_branch();
      test_bnr();
      test_mem();
      test_illegal();
      test_reset_mid();
      test_halt();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
